shift_sequencer: RTL

Multi-cycle controller that shares one 8-bit step shifter between two requesters. It arbitrates round-robin, latches the winner's operand, shift amount and direction, and applies the shift in chunks of at most 7 positions per clock until the full amount is done. It returns the result on a valid/ready output port tagged with the requester ID. It sits in front of the shift datapath and lets shift amounts of any size in 0..31 reuse the 0..7 shifter.

---
 rtl/shift_seq_pkg.sv | 44 ++++
 rtl/shift_sequencer_step.sv | 31 +++
 rtl/shift_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared constants, FSM state type, request record and the
// small arithmetic helpers used by the shift sequencer.
package shift_seq_pkg;

    localparam int WIDTH    = 8;                    // operand width (power of two, >= 8)
    localparam int AMT_W    = 5;                    // shift-amount width
    localparam int STEP_MAX = 7;                    // positions the step shifter moves per clock
    localparam int STEP_W   = $clog2(STEP_MAX + 1); // width of one step amount
    localparam int LOG2W    = $clog2(WIDTH);        // bits kept for a rotate amount
    localparam int REM_W    = LOG2W + 1;            // remaining count must be able to hold WIDTH

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic             dir;   // 1 = left, 0 = right
        logic             rot;   // 1 = rotate, 0 = zero-fill
    } req_t;

    // Positions to move this cycle: whatever is left, capped at the shifter range.
    function automatic logic [STEP_W-1:0] min_step(input logic [REM_W-1:0] rem);
        if (rem > REM_W'(STEP_MAX))
            return STEP_W'(STEP_MAX);
        else
            return rem[STEP_W-1:0];
    endfunction

    // Work actually needed: a rotate repeats every WIDTH positions, a logical
    // shift saturates at WIDTH (everything shifted out).
    function automatic logic [REM_W-1:0] eff_amt(input logic [AMT_W-1:0] amt, input logic rot);
        if (rot)
            return REM_W'(amt[LOG2W-1:0]);
        else if (amt >= AMT_W'(WIDTH))
            return REM_W'(WIDTH);
        else
            return amt[REM_W-1:0];
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// shift_step: combinational W-bit shift/rotate by 0..2^SW-1 positions.
module shift_step #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic [W-1:0]  i_data,
    input  logic [SW-1:0] i_amt,
    input  logic          i_dir,
    input  logic          i_rot,
    output logic [W-1:0]  o_data
);

    logic [W-1:0] w_lsh;
    logic [W-1:0] w_rsh;
    logic [W-1:0] w_lwrap;
    logic [W-1:0] w_rwrap;

    // Plain shifts plus the bits that wrap around; a shift by W yields 0, so
    // an amount of 0 adds no wrapped bits.
    always_comb begin
        w_lsh   = i_data << i_amt;
        w_rsh   = i_data >> i_amt;
        w_lwrap = i_data >> (W - int'(i_amt));
        w_rwrap = i_data << (W - int'(i_amt));
        if (i_dir)
            o_data = i_rot ? (w_lsh | w_lwrap) : w_lsh;
        else
            o_data = i_rot ? (w_rsh | w_rwrap) : w_rsh;
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin shares one STEP_MAX-position shifter between
// two requesters, applying amounts up to 31 over several clocks.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (adds req0_rot/req1_rot ports).
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_dir,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_dir,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             req0_rot,
    input  logic             req1_rot,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_data;
    logic [REM_W-1:0]  r_rem;
    logic              r_dir;
    logic              r_rot;
    logic              r_id;
    logic              r_last;    // requester served most recently

    req_t              w_req0;
    req_t              w_req1;
    req_t              w_sel;
    logic              w_any;
    logic              w_pick1;
    logic              w_accept;
    logic [REM_W-1:0]  w_eff;
    logic [STEP_W-1:0] w_step;
    logic [REM_W-1:0]  w_rem_nxt;
    logic [WIDTH-1:0]  w_shifted;

    assign w_req0.data = req0_data;
    assign w_req0.amt  = req0_amt;
    assign w_req0.dir  = req0_dir;
    assign w_req1.data = req1_data;
    assign w_req1.amt  = req1_amt;
    assign w_req1.dir  = req1_dir;
`ifdef SHIFT_SEQ_ROTATE_EN
    assign w_req0.rot  = req0_rot;
    assign w_req1.rot  = req1_rot;
`else
    assign w_req0.rot  = 1'b0;
    assign w_req1.rot  = 1'b0;
`endif

    // Arbitration pick is independent of state; the FSM decides whether to grant it.
    assign w_any     = req0_valid | req1_valid;
    assign w_pick1   = req1_valid & (~req0_valid | ~r_last);
    assign w_sel     = w_pick1 ? w_req1 : w_req0;
    assign w_eff     = eff_amt(w_sel.amt, w_sel.rot);
    assign w_accept  = gnt0 | gnt1;

    assign w_step    = min_step(r_rem);
    assign w_rem_nxt = r_rem - REM_W'(w_step);

    assign out_data  = r_data;
    assign out_id    = r_id;

    shift_step #(
        .W  (WIDTH),
        .SW (STEP_W)
    ) u_step (
        .i_data (r_data),
        .i_amt  (w_step),
        .i_dir  (r_dir),
        .i_rot  (r_rot),
        .o_data (w_shifted)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, grants and status outputs; grants are held off while in reset.
    always_comb begin
        w_state_nxt = r_state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n && w_any) begin
                    gnt0        = ~w_pick1;
                    gnt1        = w_pick1;
                    w_state_nxt = (w_eff != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_rem_nxt == '0) w_state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, then one step per SHIFT cycle; frozen in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_rem  <= '0;
            r_dir  <= 1'b0;
            r_rot  <= 1'b0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data <= w_sel.data;
                        r_dir  <= w_sel.dir;
                        r_rot  <= w_sel.rot;
                        r_rem  <= w_eff;
                        r_id   <= w_pick1;
                        r_last <= w_pick1;
                    end
                end
                SHIFT: begin
                    r_data <= w_shifted;
                    r_rem  <= w_rem_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule
